// File: rtl/i2c_pkg.sv
// Shared I2C types: transfer direction, target controller state encoding and
// the default address the target controller answers to.
`timescale 1ns/1ps

package i2c_pkg;

    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_target_state_t;

    localparam logic [6:0] I2C_TARGET_ADDR_DEFAULT = 7'h22;

endpackage

// File: rtl/i2c_line_sync.sv
// One I2C bus line into the clk_i domain: 2-flop synchronizer, optional 3-tap
// majority glitch filter (I2C_TARGET_GLITCH_FILTER_EN), registered edge detect.
// level_o is aligned with rise_o/fall_o: it already shows the post-edge value.
// Flops reset to 1 because an idle bus line sits high; this avoids a false
// edge right after reset.
`timescale 1ns/1ps

module i2c_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_reg;
    logic sync2_reg;
    logic clean;
    logic prev_reg;
    logic rise_reg;
    logic fall_reg;

    // Two-stage synchronizer for the asynchronous pin
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= line_i;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic tap0_reg;
    logic tap1_reg;
    logic filt_reg;

    // Majority of three consecutive samples: a single-cycle pulse never wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tap0_reg <= 1'b1;
            tap1_reg <= 1'b1;
            filt_reg <= 1'b1;
        end else begin
            tap0_reg <= sync2_reg;
            tap1_reg <= tap0_reg;
            filt_reg <= (sync2_reg & tap0_reg) | (sync2_reg & tap1_reg) | (tap0_reg & tap1_reg);
        end
    end

    assign clean = filt_reg;
`else
    assign clean = sync2_reg;
`endif

    // Registered edge detection on the cleaned line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_reg <= 1'b1;
            rise_reg <= 1'b0;
            fall_reg <= 1'b0;
        end else begin
            prev_reg <= clean;
            rise_reg <= clean & ~prev_reg;
            fall_reg <= ~clean & prev_reg;
        end
    end

    assign level_o = prev_reg;
    assign rise_o  = rise_reg;
    assign fall_o  = fall_reg;

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target controller: decodes START/STOP/address/data from oversampled
// SCL/SDA, ACKs its own address, streams written bytes to the host and
// fetches read bytes from it. SDA is only ever pulled low (open-drain) and
// only changes one cycle after a detected SCL fall.
// Optional glitch filter in the line synchronizers: I2C_TARGET_GLITCH_FILTER_EN.
`timescale 1ns/1ps

module i2c_target_ctrl
    import i2c_pkg::*;
#(
    parameter int                        I2C_ADDR_WIDTH = 7,
    parameter int                        I2C_DATA_WIDTH = 8,
    parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = I2C_ADDR_WIDTH'(I2C_TARGET_ADDR_DEFAULT)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      sda_oe_o,
    output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
    output logic                      tx_taken_o,
    output logic                      busy_o,
    output logic                      op_o,
    output logic                      start_o,
    output logic                      stop_o
);

    localparam int                CNT_W    = $clog2(I2C_DATA_WIDTH + 1);
    localparam int                IDX_W    = $clog2(I2C_DATA_WIDTH);
    localparam logic [CNT_W-1:0]  BYTE_END = CNT_W'(I2C_DATA_WIDTH);

    // Index 0 = SDA, index 1 = SCL
    logic [1:0] line_raw;
    logic [1:0] line_level;
    logic [1:0] line_rise;
    logic [1:0] line_fall;

    assign line_raw = {scl_i, sda_i};

    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        i2c_line_sync u_sync (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .line_i  (line_raw[gi]),
            .level_o (line_level[gi]),
            .rise_o  (line_rise[gi]),
            .fall_o  (line_fall[gi])
        );
    end

    logic sda_level;
    logic scl_level;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign sda_level = line_level[0];
    assign scl_level = line_level[1];
    assign scl_rise  = line_rise[1];
    assign scl_fall  = line_fall[1];
    // An SCL edge in the same sample masks any SDA edge
    assign start_det = line_fall[0] & scl_level & ~scl_rise & ~scl_fall;
    assign stop_det  = line_rise[0] & scl_level & ~scl_rise & ~scl_fall;

    i2c_target_state_t         state_reg,    state_next;
    logic [CNT_W-1:0]          bit_cnt_reg,  bit_cnt_next;
    logic [I2C_DATA_WIDTH-1:0] shift_reg,    shift_next;
    logic [I2C_DATA_WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic [I2C_DATA_WIDTH-1:0] rx_data_reg,  rx_data_next;
    i2c_op_t                   op_reg,       op_next;
    logic                      busy_reg,     busy_next;
    logic                      sda_oe_reg,   sda_oe_next;
    logic                      rx_valid_reg, rx_valid_next;
    logic                      tx_taken_reg, tx_taken_next;
    logic                      start_reg,    start_next;
    logic                      stop_reg,     stop_next;
    logic [IDX_W-1:0]          rd_idx;

    // State and output registers; reset releases SDA asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            tx_shift_reg <= '0;
            rx_data_reg  <= '0;
            op_reg       <= I2C_WRITE;
            busy_reg     <= 1'b0;
            sda_oe_reg   <= 1'b0;
            rx_valid_reg <= 1'b0;
            tx_taken_reg <= 1'b0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_shift_reg <= tx_shift_next;
            rx_data_reg  <= rx_data_next;
            op_reg       <= op_next;
            busy_reg     <= busy_next;
            sda_oe_reg   <= sda_oe_next;
            rx_valid_reg <= rx_valid_next;
            tx_taken_reg <= tx_taken_next;
            start_reg    <= start_next;
            stop_reg     <= stop_next;
        end
    end

    // Next-state and output decode; START/STOP override every state
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        tx_shift_next = tx_shift_reg;
        rx_data_next  = rx_data_reg;
        op_next       = op_reg;
        busy_next     = busy_reg;
        sda_oe_next   = sda_oe_reg;
        rx_valid_next = 1'b0;
        tx_taken_next = 1'b0;
        start_next    = 1'b0;
        stop_next     = 1'b0;
        // Bit to present next: MSB after the ack, then one lower per SCL rise seen
        rd_idx        = IDX_W'(I2C_DATA_WIDTH - 1) - IDX_W'(bit_cnt_reg);

        if (start_det) begin
            start_next   = 1'b1;
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            busy_next    = 1'b0;
            sda_oe_next  = 1'b0;
        end else if (stop_det) begin
            stop_next   = 1'b1;
            state_next  = ST_IDLE;
            busy_next   = 1'b0;
            sda_oe_next = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[I2C_DATA_WIDTH-2:0], sda_level};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else if (scl_fall && bit_cnt_reg == BYTE_END) begin
                        if (shift_reg[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == TARGET_ADDR) begin
                            state_next  = ST_ADDR_ACK;
                            op_next     = i2c_op_t'(shift_reg[0]);
                            busy_next   = 1'b1;
                            sda_oe_next = 1'b1;
                        end else begin
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = '0;
                        if (op_reg == I2C_WRITE) begin
                            state_next  = ST_WR_DATA;
                            sda_oe_next = 1'b0;
                        end else begin
                            state_next    = ST_RD_DATA;
                            tx_shift_next = tx_data_i;
                            tx_taken_next = 1'b1;
                            sda_oe_next   = ~tx_data_i[I2C_DATA_WIDTH-1];
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[I2C_DATA_WIDTH-2:0], sda_level};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else if (scl_fall && bit_cnt_reg == BYTE_END) begin
                        if (rx_ready_i) begin
                            rx_data_next  = shift_reg;
                            rx_valid_next = 1'b1;
                            sda_oe_next   = 1'b1;
                            state_next    = ST_WR_ACK;
                        end else begin
                            busy_next  = 1'b0;
                            state_next = ST_IGNORE;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = '0;
                        state_next   = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == BYTE_END) begin
                            sda_oe_next = 1'b0;
                            state_next  = ST_RD_ACK;
                        end else begin
                            sda_oe_next = ~tx_shift_reg[rd_idx];
                        end
                    end
                end
                ST_RD_ACK: begin
                    // A NACK is known at the SCL rise; reaching the fall means ACK
                    if (scl_rise && sda_level) begin
                        busy_next  = 1'b0;
                        state_next = ST_IGNORE;
                    end else if (scl_fall) begin
                        bit_cnt_next  = '0;
                        tx_shift_next = tx_data_i;
                        tx_taken_next = 1'b1;
                        sda_oe_next   = ~tx_data_i[I2C_DATA_WIDTH-1];
                        state_next    = ST_RD_DATA;
                    end
                end
                default: begin
                    // IDLE and IGNORE wait for START/STOP with SDA released
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe_o   = sda_oe_reg;
    assign rx_data_o  = rx_data_reg;
    assign rx_valid_o = rx_valid_reg;
    assign tx_taken_o = tx_taken_reg;
    assign busy_o     = busy_reg;
    assign op_o       = op_reg;
    assign start_o    = start_reg;
    assign stop_o     = stop_reg;

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Bench for i2c_target_ctrl: a bus-master model drives SCL/SDA (wired-AND with
// the target's pull-down); expected host-side pulses go into a queue that a
// separate monitor pops and compares as the DUT produces them.
`timescale 1ns/1ps

module tb_i2c_target_ctrl;
    import i2c_pkg::*;

    localparam int Q = 60;   // quarter-bit time (6 clk cycles)
    localparam int H = 120;  // SCL high time

    localparam int EV_START = 0;
    localparam int EV_STOP  = 1;
    localparam int EV_RX    = 2;
    localparam int EV_TX    = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_taken;
    logic       busy;
    logic       op;
    logic       start_p;
    logic       stop_p;

    int   checks   = 0;
    int   failures = 0;
    logic oe_seen  = 1'b0;
    ev_t  exp_q[$];

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_ctrl dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .tx_data_i  (tx_data),
        .tx_taken_o (tx_taken),
        .busy_o     (busy),
        .op_o       (op),
        .start_o    (start_p),
        .stop_o     (stop_p)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", kind, 32'hFFFF);
        end else begin
            e = exp_q.pop_front();
            check("sb_event_kind", kind, e.kind);
            if (kind == EV_RX) check("sb_rx_data", rx_data, e.data);
        end
    endtask

    // Monitor: compare every host-side pulse against the expected queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sda_oe) oe_seen = 1'b1;
                if (start_p)  sb_pop(EV_START);
                if (stop_p)   sb_pop(EV_STOP);
                if (rx_valid) sb_pop(EV_RX);
                if (tx_taken) sb_pop(EV_TX);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_sda_oe"},   sda_oe,   0);
        check({tag, "_rx_data"},  rx_data,  0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_tx_taken"}, tx_taken, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_op"},       op,       0);
        check({tag, "_start"},    start_p,  0);
        check({tag, "_stop"},     stop_p,   0);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    #Q;
        scl_m = 1'b1; #H;
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #(H/2);
        b = sda_bus;  #(H/2);
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    initial begin
        logic       ack_n;
        logic [7:0] rd;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_ready = 1'b1; tx_data = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Write 0x22 + {A5, 3C}
        push(EV_START, 0); push(EV_RX, 8'hA5); push(EV_RX, 8'h3C); push(EV_STOP, 0);
        i2c_start();
        write_byte(8'h44, ack_n); check("wr_addr_ack_n", ack_n, 0);
        check("wr_busy", busy, 1);
        check("wr_op", op, 0);
        write_byte(8'hA5, ack_n); check("wr_byte0_ack_n", ack_n, 0);
        write_byte(8'h3C, ack_n); check("wr_byte1_ack_n", ack_n, 0);
        i2c_stop();
        #(2*H);
        check("wr_busy_after_stop", busy, 0);

        // Write to 0x23: not addressed
        oe_seen = 1'b0;
        push(EV_START, 0); push(EV_STOP, 0);
        i2c_start();
        write_byte(8'h46, ack_n); check("other_addr_ack_n", ack_n, 1);
        check("other_busy", busy, 0);
        write_byte(8'h00, ack_n); check("other_data_ack_n", ack_n, 1);
        i2c_stop();
        #(2*H);
        check("other_no_drive", oe_seen, 0);

        // Read 0x22: 5A (master ACK) then F0 (master NACK)
        tx_data = 8'h5A;
        push(EV_START, 0); push(EV_TX, 0); push(EV_TX, 0); push(EV_STOP, 0);
        i2c_start();
        write_byte(8'h45, ack_n); check("rd_addr_ack_n", ack_n, 0);
        check("rd_op", op, 1);
        check("rd_busy", busy, 1);
        read_byte(rd); check("rd_byte0", rd, 8'h5A);
        tx_data = 8'hF0;
        write_bit(1'b0);
        read_byte(rd); check("rd_byte1", rd, 8'hF0);
        tx_data = 8'h00;
        write_bit(1'b1);
        check("rd_released_after_nack", sda_oe, 0);
        read_bit(ack_n); check("rd_bus_idle_after_nack", ack_n, 1);
        i2c_stop();
        #(2*H);

        // Write 0x11, repeated START, read
        tx_data = 8'h77;
        push(EV_START, 0); push(EV_RX, 8'h11); push(EV_START, 0); push(EV_TX, 0); push(EV_STOP, 0);
        i2c_start();
        write_byte(8'h44, ack_n); check("rs_wr_addr_ack_n", ack_n, 0);
        write_byte(8'h11, ack_n); check("rs_wr_data_ack_n", ack_n, 0);
        i2c_start();
        write_byte(8'h45, ack_n); check("rs_rd_addr_ack_n", ack_n, 0);
        check("rs_op_read", op, 1);
        check("rs_busy", busy, 1);
        read_byte(rd); check("rs_rd_byte", rd, 8'h77);
        write_bit(1'b1);
        i2c_stop();
        #(2*H);

        // Host not ready at the second byte
        push(EV_START, 0); push(EV_RX, 8'h12); push(EV_STOP, 0);
        i2c_start();
        write_byte(8'h44, ack_n); check("nr_addr_ack_n", ack_n, 0);
        write_byte(8'h12, ack_n); check("nr_byte0_ack_n", ack_n, 0);
        rx_ready = 1'b0;
        write_byte(8'h34, ack_n); check("nr_byte1_nack", ack_n, 1);
        rx_ready = 1'b1;
        write_byte(8'h56, ack_n); check("nr_ignored_nack", ack_n, 1);
        i2c_stop();
        #(2*H);

        // Reset while the target pulls SDA low during a read
        tx_data = 8'h00;
        push(EV_START, 0); push(EV_TX, 0);
        i2c_start();
        write_byte(8'h45, ack_n); check("rst_addr_ack_n", ack_n, 0);
        check("rst_driving_before", sda_oe, 1);
        scl_m = 1'b1; #(H/2);
        check("rst_sda_low_before", sda_bus, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        #(H/2);
        scl_m = 1'b0; #Q;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push(EV_STOP, 0);
        i2c_stop();
        push(EV_START, 0); push(EV_RX, 8'h99); push(EV_STOP, 0);
        i2c_start();
        write_byte(8'h44, ack_n); check("post_rst_addr_ack_n", ack_n, 0);
        write_byte(8'h99, ack_n); check("post_rst_data_ack_n", ack_n, 0);
        i2c_stop();
        #(4*H);

        check("sb_all_events_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
